// File: rtl/rom_loader_pkg.sv
// Shared definitions for the framed-byte ROM/RAM loader: state encoding, the
// default frame marker and the 8-bit checksum step.
package rom_loader_pkg;

  typedef enum logic [3:0] {
    StSync,
    StAddrHi,
    StAddrLo,
    StLenHi,
    StLenLo,
    StData,
    StChk,
    StDone,
    StError
  } loader_state_e;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  // Modulo-256 accumulate; the carry is deliberately dropped.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/rom_loader.sv
// Receives SYNC/ADDR/LEN/DATA/CHK frames from a byte stream, writes the data
// bytes to consecutive memory addresses and releases the CPU on a good checksum.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH = 8,
  parameter int unsigned     ADDR_WIDTH = 16,
  parameter logic [7:0]      SYNC_BYTE  = LOADER_SYNC
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_cpu_hold,
  output logic                  o_load_done,
  output logic                  o_load_error
);

  loader_state_e r_state;
  loader_state_e w_state_next;

  logic [15:0]           r_addr;
  logic [15:0]           r_cnt;
  logic [7:0]            r_chk;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_cpu_hold;
  logic                  r_load_done;
  logic                  r_load_error;

  logic [15:0]           w_addr_next;
  logic [15:0]           w_cnt_next;
  logic [7:0]            w_chk_next;
  logic                  w_mem_we_next;
  logic [ADDR_WIDTH-1:0] w_mem_addr_next;
  logic [DATA_WIDTH-1:0] w_mem_wdata_next;
  logic                  w_cpu_hold_next;
  logic                  w_load_done_next;
  logic                  w_load_error_next;

  logic [7:0]            w_byte;
  logic [7:0]            w_chk_sum;
  logic                  w_is_sync;
  logic                  w_accept;

  // No backpressure: every offered byte is consumed in the cycle it appears.
  assign o_in_ready = 1'b1;
  assign w_accept   = i_in_valid;
  assign w_byte     = i_in_data[7:0];
  assign w_is_sync  = (w_byte == SYNC_BYTE);
  assign w_chk_sum  = chk_add(r_chk, w_byte);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StSync;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_chk        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_addr       <= w_addr_next;
      r_cnt        <= w_cnt_next;
      r_chk        <= w_chk_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_cpu_hold   <= w_cpu_hold_next;
      r_load_done  <= w_load_done_next;
      r_load_error <= w_load_error_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_cnt_next        = r_cnt;
    w_chk_next        = r_chk;
    w_mem_we_next     = 1'b0;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_cpu_hold_next   = r_cpu_hold;
    w_load_done_next  = r_load_done;
    w_load_error_next = r_load_error;

    if (w_accept) begin
      case (r_state)
        StSync: begin
          if (w_is_sync) begin
            w_state_next = StAddrHi;
            w_chk_next   = 8'h00;
          end
        end
        StAddrHi: begin
          w_addr_next[15:8] = w_byte;
          w_chk_next        = w_chk_sum;
          w_state_next      = StAddrLo;
        end
        StAddrLo: begin
          w_addr_next[7:0] = w_byte;
          w_chk_next       = w_chk_sum;
          w_state_next     = StLenHi;
        end
        StLenHi: begin
          w_cnt_next[15:8] = w_byte;
          w_chk_next       = w_chk_sum;
          w_state_next     = StLenLo;
        end
        StLenLo: begin
          w_cnt_next[7:0] = w_byte;
          w_chk_next      = w_chk_sum;
          w_state_next    = ({r_cnt[15:8], w_byte} == 16'h0000) ? StChk : StData;
        end
        StData: begin
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = r_addr[ADDR_WIDTH-1:0];
          w_mem_wdata_next = i_in_data;
          w_addr_next      = r_addr + 16'd1;
          w_cnt_next       = r_cnt - 16'd1;
          w_chk_next       = w_chk_sum;
          if (r_cnt == 16'd1) begin
            w_state_next = StChk;
          end
        end
        StChk: begin
          w_chk_next = w_chk_sum;
          if (w_chk_sum == 8'h00) begin
            w_state_next     = StDone;
            w_load_done_next = 1'b1;
            w_cpu_hold_next  = 1'b0;
          end else begin
            w_state_next      = StError;
            w_load_error_next = 1'b1;
          end
        end
        StDone, StError: begin
          // A new frame re-captures the CPU on the same edge it starts.
          if (w_is_sync) begin
            w_state_next      = StAddrHi;
            w_chk_next        = 8'h00;
            w_load_done_next  = 1'b0;
            w_load_error_next = 1'b0;
            w_cpu_hold_next   = 1'b1;
          end
        end
        default: begin
          w_state_next = StSync;
        end
      endcase
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_load_done  = r_load_done;
  assign o_load_error = r_load_error;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader: frames are built from the frame/checksum
// rules and expected writes are queued with their required cycle.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  rom_loader #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (16),
    .SYNC_BYTE  (8'hA5)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_cpu_hold   (cpu_hold),
    .o_load_done  (load_done),
    .o_load_error (load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] payload[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check_eq("we_addr", {16'h0, mem_addr}, {16'h0, w.addr});
        check_eq("we_data", {24'h0, mem_wdata}, {24'h0, w.data});
        check_eq("we_cycle", cyc, w.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_flags(input string tag, input bit done, input bit err, input bit hold);
    check_eq({tag, "_done"}, {31'h0, load_done}, {31'h0, done});
    check_eq({tag, "_error"}, {31'h0, load_error}, {31'h0, err});
    check_eq({tag, "_hold"}, {31'h0, cpu_hold}, {31'h0, hold});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, {31'h0, mem_we}, 32'h0);
    check_eq({tag, "_addr"}, {16'h0, mem_addr}, 32'h0);
    check_eq({tag, "_wdata"}, {24'h0, mem_wdata}, 32'h0);
    check_eq({tag, "_ready"}, {31'h0, in_ready}, 32'h1);
    check_flags(tag, 1'b0, 1'b0, 1'b1);
  endtask

  // Sends SYNC + header + payload (+ CHK unless truncated at n_data bytes).
  task automatic send_frame(input logic [15:0] addr, input bit bad, input int gap,
                            input int n_data);
    logic [7:0]  sum;
    logic [7:0]  hdr[4];
    logic [15:0] len;
    logic [15:0] a;
    logic [7:0]  chk;
    wr_t         w;
    len    = 16'(payload.size());
    hdr[0] = addr[15:8];
    hdr[1] = addr[7:0];
    hdr[2] = len[15:8];
    hdr[3] = len[7:0];
    sum    = 8'h00;
    send_byte(8'hA5);
    check_flags("after_sync", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(gap);
      send_byte(hdr[i]);
      sum = sum + hdr[i];
    end
    a = addr;
    for (int i = 0; i < n_data; i++) begin
      idle(gap);
      send_byte(payload[i]);
      w.cyc  = cyc;
      w.addr = a;
      w.data = payload[i];
      exp_q.push_back(w);
      sum = sum + payload[i];
      a   = a + 16'd1;
    end
    if (n_data == payload.size()) begin
      chk = 8'h00 - sum;
      if (bad) chk = chk + 8'($urandom_range(1, 255));
      idle(gap);
      send_byte(chk);
      check_flags("after_chk", !bad, bad, bad);
    end
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      send_byte(b);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    int          rlen;
    bit          rbad;

    idle(3);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    #1;
    check_reset_outputs("post_reset");

    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(16'hF000, 1'b0, 0, 3);
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(16'hF000, 1'b1, 0, 3);
    send_garbage(3);
    check_flags("error_ignore", 1'b0, 1'b1, 1'b1);
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(16'hF000, 1'b0, 1, 3);

    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check_flags("done_ignore", 1'b1, 1'b0, 1'b0);
    payload = '{8'h7E};
    send_frame(16'h1234, 1'b0, 0, 1);

    payload.delete();
    send_frame(16'h2000, 1'b0, 0, 0);

    payload = '{8'hAA, 8'hBB};
    send_frame(16'hFFFF, 1'b0, 0, 2);

    // Gapped frame aborted by reset after two data bytes.
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(16'h3000, 1'b0, 3, 2);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    #1;
    check_reset_outputs("mid_release");
    payload = '{8'h5C, 8'hC5};
    send_frame(16'h4000, 1'b0, 0, 2);

    for (int f = 0; f < 30; f++) begin
      send_garbage(int'($urandom_range(0, 2)));
      ra   = 16'($urandom);
      rlen = int'($urandom_range(0, 6));
      rbad = ($urandom_range(0, 3) == 0);
      payload.delete();
      for (int i = 0; i < rlen; i++) payload.push_back(8'($urandom));
      send_frame(ra, rbad, int'($urandom_range(0, 2)), rlen);
    end

    idle(4);
    check_eq("pending_writes", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
